// File: rtl/sequential_updown_psc.sv
// Prescaled up/down counter with wrap or saturate at the 0..MAX bounds.
// The terminal-count pulse is registered and follows any tick taken at a bound.
module sequential_updown_psc #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      PRESCALE = 1,
  parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] io_in,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_oeb,
  output logic             tc
);

  localparam int unsigned PSC_W    = 8;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  logic             clr, en, dir, ld, sat;
  logic [WIDTH-1:0] ctr_q, ctr_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] ld_clamped;
  logic             tick;
  logic             unused_io;

  assign clr = io_in[0];
  assign en  = io_in[1];
  assign dir = io_in[2];
  assign ld  = io_in[3];
  assign sat = io_in[4];
  assign unused_io = ^io_in[WIDTH-1:5];

  // A full-range MAX needs no clamp; skipping it avoids a constant compare.
  generate
    if (MAX == {WIDTH{1'b1}}) begin : g_noclamp
      assign ld_clamped = load_val;
    end else begin : g_clamp
      assign ld_clamped = (load_val > MAX) ? MAX : load_val;
    end
  endgenerate

  assign tick = (psc_q == PSC_LAST);

  always_comb begin
    ctr_d = ctr_q;
    psc_d = psc_q;
    tc_d  = 1'b0;
    if (en) begin
      if (clr) begin
        ctr_d = '0;
        psc_d = '0;
      end else if (ld) begin
        ctr_d = ld_clamped;
        psc_d = '0;
      end else begin
        psc_d = tick ? '0 : psc_q + PSC_W'(1);
        if (tick) begin
          if (dir) begin
            if (ctr_q == MAX) begin
              ctr_d = sat ? MAX : '0;
              tc_d  = 1'b1;
            end else begin
              ctr_d = ctr_q + WIDTH'(1);
            end
          end else begin
            if (ctr_q == '0) begin
              ctr_d = sat ? '0 : MAX;
              tc_d  = 1'b1;
            end else begin
              ctr_d = ctr_q - WIDTH'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_q <= '0;
      psc_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      ctr_q <= ctr_d;
      psc_q <= psc_d;
      tc_q  <= tc_d;
    end
  end

  assign io_out = ctr_q;
  assign io_oeb = {WIDTH{1'b1}};
  assign tc     = tc_q;

endmodule

// File: tb/tb_sequential_updown_psc.sv
// Five parameterisations share one stimulus stream; a bench model checks them
// every cycle, and directed scenarios pin literal values.
module tb_sequential_updown_psc;

  localparam int N = 5;
  // 0: P=3, 1: P=1, 2: P=1 MAX=9, 3: P=1 MAX=100, 4: P=4
  localparam int PS [N] = '{3, 1, 1, 1, 4};
  localparam int MX [N] = '{255, 255, 9, 100, 255};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] io_in = 8'h00;
  logic [7:0] load_val = 8'h00;
  logic [7:0] out_w [N];
  logic [7:0] oeb_w [N];
  logic       tc_w  [N];

  int checks = 0;
  int errors = 0;

  int m_ctr [N] = '{0, 0, 0, 0, 0};
  int m_psc [N] = '{0, 0, 0, 0, 0};
  int m_tc  [N] = '{0, 0, 0, 0, 0};

  always #5 clk = ~clk;

  sequential_updown_psc #(.WIDTH(8), .PRESCALE(3), .MAX(8'd255)) u0 (
    .clk(clk), .rst_n(rst_n), .io_in(io_in), .load_val(load_val),
    .io_out(out_w[0]), .io_oeb(oeb_w[0]), .tc(tc_w[0]));
  sequential_updown_psc #(.WIDTH(8), .PRESCALE(1), .MAX(8'd255)) u1 (
    .clk(clk), .rst_n(rst_n), .io_in(io_in), .load_val(load_val),
    .io_out(out_w[1]), .io_oeb(oeb_w[1]), .tc(tc_w[1]));
  sequential_updown_psc #(.WIDTH(8), .PRESCALE(1), .MAX(8'd9)) u2 (
    .clk(clk), .rst_n(rst_n), .io_in(io_in), .load_val(load_val),
    .io_out(out_w[2]), .io_oeb(oeb_w[2]), .tc(tc_w[2]));
  sequential_updown_psc #(.WIDTH(8), .PRESCALE(1), .MAX(8'd100)) u3 (
    .clk(clk), .rst_n(rst_n), .io_in(io_in), .load_val(load_val),
    .io_out(out_w[3]), .io_oeb(oeb_w[3]), .tc(tc_w[3]));
  sequential_updown_psc #(.WIDTH(8), .PRESCALE(4), .MAX(8'd255)) u4 (
    .clk(clk), .rst_n(rst_n), .io_in(io_in), .load_val(load_val),
    .io_out(out_w[4]), .io_oeb(oeb_w[4]), .tc(tc_w[4]));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: count enabled cycles, step by +/-1, fold out-of-range.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < N; k++) begin
      int c, p, t, n;
      c = m_ctr[k]; p = m_psc[k]; t = 0;
      if (!rst_n) begin
        c = 0; p = 0;
      end else if (io_in[1]) begin
        if (io_in[0]) begin
          c = 0; p = 0;
        end else if (io_in[3]) begin
          c = (int'(load_val) < MX[k]) ? int'(load_val) : MX[k];
          p = 0;
        end else begin
          p = p + 1;
          if (p == PS[k]) begin
            p = 0;
            n = io_in[2] ? c + 1 : c - 1;
            if (n > MX[k] || n < 0) begin
              t = 1;
              if (io_in[4]) c = io_in[2] ? MX[k] : 0;
              else          c = io_in[2] ? 0 : MX[k];
            end else begin
              c = n;
            end
          end
        end
      end
      m_ctr[k] <= c;
      m_psc[k] <= p;
      m_tc[k]  <= t;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      chk($sformatf("model_out[%0d]", k), int'(out_w[k]), m_ctr[k]);
      chk($sformatf("model_tc[%0d]", k), int'(tc_w[k]), m_tc[k]);
      chk($sformatf("oeb[%0d]", k), int'(oeb_w[k]), 255);
    end
  end

  int exp_a [10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3};
  logic [7:0] tbl [10] = '{8'h06, 8'hE6, 8'h04, 8'h02, 8'h02,
                           8'h12, 8'h16, 8'h00, 8'h0A, 8'h03};

  initial begin
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("reset_out[%0d]", k), int'(out_w[k]), 0);
      chk($sformatf("reset_tc[%0d]", k), int'(tc_w[k]), 0);
    end
    rst_n = 1'b1;

    // Prescale by 3, counting up
    io_in = 8'h06;
    chk("psc3_step0", int'(out_w[0]), exp_a[0]);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("psc3_step%0d", i), int'(out_w[0]), exp_a[i]);
      chk($sformatf("psc3_tc%0d", i), int'(tc_w[0]), 0);
    end

    // Up wrap through 255
    io_in = 8'h0A; load_val = 8'd254;
    @(negedge clk); chk("wrap_ld", int'(out_w[1]), 254); chk("wrap_ld_tc", int'(tc_w[1]), 0);
    io_in = 8'h06;
    @(negedge clk); chk("wrap_255", int'(out_w[1]), 255); chk("wrap_255_tc", int'(tc_w[1]), 0);
    @(negedge clk); chk("wrap_0", int'(out_w[1]), 0);     chk("wrap_0_tc", int'(tc_w[1]), 1);
    @(negedge clk); chk("wrap_1", int'(out_w[1]), 1);     chk("wrap_1_tc", int'(tc_w[1]), 0);

    // MAX=9 down saturate, then down wrap
    io_in = 8'h0A; load_val = 8'd0;
    @(negedge clk); chk("sat_ld", int'(out_w[2]), 0);
    io_in = 8'h12;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("sat_hold%0d", i), int'(out_w[2]), 0);
      chk($sformatf("sat_tc%0d", i), int'(tc_w[2]), 1);
    end
    io_in = 8'h02;
    @(negedge clk); chk("dn_wrap", int'(out_w[2]), 9); chk("dn_wrap_tc", int'(tc_w[2]), 1);

    // clr beats ld; nothing acts without en
    io_in = 8'h0A; load_val = 8'h33;
    @(negedge clk);
    io_in = 8'h0B; load_val = 8'h55;
    @(negedge clk); chk("clr_over_ld", int'(out_w[1]), 0);
    io_in = 8'h0A; load_val = 8'h33;
    @(negedge clk);
    io_in = 8'h09; load_val = 8'h55;
    @(negedge clk); chk("no_en_hold", int'(out_w[1]), 8'h33); chk("no_en_tc", int'(tc_w[1]), 0);

    // MAX=100 load clamp then wrap
    io_in = 8'h0A; load_val = 8'd200;
    @(negedge clk); chk("clamp_ld", int'(out_w[3]), 100);
    io_in = 8'h06;
    @(negedge clk); chk("clamp_wrap", int'(out_w[3]), 0); chk("clamp_wrap_tc", int'(tc_w[3]), 1);

    // Prescale 4: async reset mid-count drops partial progress
    io_in = 8'h03;
    @(negedge clk);
    io_in = 8'h06;
    repeat (22) @(negedge clk);
    chk("psc4_pre", int'(out_w[4]), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_out4", int'(out_w[4]), 0);
    chk("areset_out1", int'(out_w[1]), 0);
    chk("areset_tc4", int'(tc_w[4]), 0);
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("psc4_after%0d", i), int'(out_w[4]), (i == 4) ? 1 : 0);
    end

    // Mixed control sweep, checked by the model only
    for (int i = 0; i < 60; i++) begin
      io_in = tbl[i % 10];
      load_val = 8'(i * 37);
      @(negedge clk);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequential_updown_psc.md
SEQUENTIAL_UPDOWN_PSC -- requirements
Module: sequential_updown_psc

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, counter and I/O bus width; legal values 6 to 32.
REQ-002 The module SHALL have parameter PRESCALE, default 1, number of enabled cycles per count tick; legal values 1 to 255.
REQ-003 The module SHALL have parameter MAX, default 2**WIDTH-1, upper count bound; legal values 1 to 2**WIDTH-1.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port io_in, input, WIDTH bits, control bits as follows:
- [0] clr: synchronous clear.
- [1] en: enable.
- [2] dir: 1 = up, 0 = down.
- [3] ld: synchronous load.
- [4] sat: 1 = saturate, 0 = wrap.
- upper bits unused.
REQ-007 Port load_val, input, WIDTH bits: value loaded when ld is accepted.
REQ-008 Port io_out, output, WIDTH bits: current counter value.
REQ-009 Port io_oeb, output, WIDTH bits: driven constant all-ones.
REQ-010 Port tc, output, 1 bit: registered terminal-count pulse.

Function
REQ-011 The block SHALL hold a WIDTH-bit counter ctr and a prescaler psc; io_out SHALL equal ctr combinationally from the register, with no added latency.
REQ-012 Per-cycle priority SHALL be clr > ld > count, and each of clr, ld and count SHALL act only when en=1; with en=0, ctr, psc and the other state hold and tc=0 next cycle.
REQ-013 clr with en=1 SHALL set ctr=0 and psc=0 next cycle, and tc=0.
REQ-014 ld with en=1 and clr=0 SHALL set ctr=min(load_val, MAX) and psc=0 next cycle, and tc=0.
REQ-015 Otherwise, with en=1, psc SHALL increment each cycle; a tick occurs when psc==PRESCALE-1, in which case psc returns to 0. With PRESCALE=1, every enabled cycle is a tick.
REQ-016 Up tick, ctr<MAX: ctr SHALL become ctr+1.
REQ-017 Up tick, ctr==MAX: ctr SHALL become 0 if sat=0, and SHALL hold MAX if sat=1.
REQ-018 Down tick, ctr>0: ctr SHALL become ctr-1.
REQ-019 Down tick, ctr==0: ctr SHALL become MAX if sat=0, and SHALL hold 0 if sat=1.
REQ-020 tc SHALL be 1 for exactly the one cycle following a tick taken at a boundary (REQ-017 or REQ-019), in either mode, and 0 otherwise; consecutive boundary ticks in saturate mode SHALL pulse tc on each tick.
REQ-021 Changes to dir or sat SHALL take effect on the next tick and SHALL NOT alter psc.
REQ-022 Arithmetic SHALL be modulo 2**WIDTH before the MAX bound is applied; ctr SHALL never exceed MAX.

Reset
REQ-023 rst_n=0 SHALL immediately, without a clock, force ctr=0, psc=0 and tc=0, independent of all other inputs.
REQ-024 Release of rst_n SHALL be followed by normal operation from the next rising edge; assertion mid-count SHALL discard any partial prescale progress.

Verification
All scenarios use WIDTH=8, MAX=255 unless stated.
REQ-025 PRESCALE=3, en=1, dir=1, sat=0, start ctr=0, run 9 cycles -> io_out steps 0,0,0,1,1,1,2,2,2,3; tc stays 0.
REQ-026 PRESCALE=1, load 254, then count up with sat=0 -> io_out 254,255,0,1; tc=1 only in the cycle io_out first shows 0.
REQ-027 PRESCALE=1, MAX=9, load 0, count down with sat=1 for 3 cycles -> io_out holds 0; tc=1 on each of the 3 following cycles; then set sat=0 -> io_out=9 with tc=1.
REQ-028 clr=1 and ld=1 together with load_val=0x55 and en=1 -> io_out=0; with en=0 instead -> io_out unchanged.
REQ-029 MAX=100, ld with load_val=200 -> io_out=100; then an up tick with sat=0 -> io_out=0 and tc=1.
REQ-030 PRESCALE=4, count to ctr=5 with psc=2, then pulse rst_n low between clock edges -> io_out=0 immediately; after release, the first increment occurs 4 enabled cycles later.
